// File: rtl/segdisplay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : segdisplay_pkg
// Description : Shared state/source encodings and display saturation helper
//               for the seven-segment display scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package segdisplay_pkg;

    localparam logic [1:0] S_SCORE = 2'd0;
    localparam logic [1:0] S_HI    = 2'd1;
    localparam logic [1:0] S_EVENT = 2'd2;

    localparam logic [1:0] SRC_SCORE = 2'd0;
    localparam logic [1:0] SRC_HI    = 2'd1;
    localparam logic [1:0] SRC_EVT   = 2'd2;

    localparam logic [15:0] DISP_MAX = 16'd9999;

    // The BCD converter downstream only has four digits.
    function automatic logic [15:0] disp_sat(input logic [15:0] value);
        return (value > DISP_MAX) ? DISP_MAX : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/segdisplay_scheduler_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider producing a one-cycle tick every
//               TICK_DIV clock cycles; reusable as a general timebase.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/segdisplay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : segdisplay_scheduler
// Description : Time-shares the 4-digit display between score, high score and
//               event messages, with optional blinking via the enable line.
// Revision    : 1.0 - initial release
// ============================================================================
module segdisplay_scheduler
    import segdisplay_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int ROTATE_TICKS = 2000,
    parameter int EVENT_TICKS  = 1000,
    parameter int BLINK_TICKS  = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic [15:0] hiscore,
    input  logic        show_hi,
    input  logic        evt_valid,
    input  logic [15:0] evt_num,
    output logic        evt_ready,
    input  logic        blink_en,
    output logic [15:0] num_out,
    output logic        enable_out,
    output logic [1:0]  src
);

    localparam int DMAX = (ROTATE_TICKS > EVENT_TICKS) ? ROTATE_TICKS : EVENT_TICKS;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam int BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [DW-1:0] c_rot_last   = DW'(ROTATE_TICKS - 1);
    localparam logic [DW-1:0] c_evt_last   = DW'(EVENT_TICKS - 1);
    localparam logic [BW-1:0] c_blink_last = BW'(BLINK_TICKS - 1);

    logic           w_tick;
    logic [1:0]     r_state;
    logic [1:0]     w_state_next;
    logic [DW-1:0]  r_dwell;
    logic [DW-1:0]  w_dwell_next;
    logic [15:0]    r_evt;
    logic [15:0]    w_evt_next;
    logic [BW-1:0]  r_blink_cnt;
    logic [BW-1:0]  w_blink_cnt_next;
    logic           r_phase;
    logic           w_phase_next;
    logic           w_accept;
    logic           w_rot_done;
    logic [15:0]    w_src_val;
    logic [1:0]     w_src_next;
    logic [15:0]    r_num;
    logic           r_enable;
    logic [1:0]     r_src;
    logic           r_evt_ready;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_comb begin
        w_accept     = evt_valid & r_evt_ready;
        w_rot_done   = w_tick & (r_dwell == c_rot_last);
        w_state_next = r_state;
        case (r_state)
            S_SCORE: begin
                if (w_accept)                  w_state_next = S_EVENT;
                else if (show_hi && w_rot_done) w_state_next = S_HI;
            end
            S_HI: begin
                if (w_accept)        w_state_next = S_EVENT;
                else if (!show_hi)   w_state_next = S_SCORE;
                else if (w_rot_done) w_state_next = S_SCORE;
            end
            S_EVENT: begin
                if (w_tick && (r_dwell == c_evt_last)) w_state_next = S_SCORE;
            end
            default: w_state_next = S_SCORE;
        endcase
    end

    // Dwell saturates in S_SCORE so rotation resumes on the next tick once
    // show_hi is raised after a long idle period.
    always_comb begin
        w_dwell_next = r_dwell;
        if (w_state_next != r_state) begin
            w_dwell_next = '0;
        end else if (w_tick) begin
            if (!((r_state == S_SCORE) && (r_dwell == c_rot_last))) begin
                w_dwell_next = r_dwell + DW'(1);
            end
        end
    end

    always_comb begin
        w_evt_next = w_accept ? evt_num : r_evt;
        w_src_val  = score;
        w_src_next = SRC_SCORE;
        case (w_state_next)
            S_HI: begin
                w_src_val  = hiscore;
                w_src_next = SRC_HI;
            end
            S_EVENT: begin
                w_src_val  = w_evt_next;
                w_src_next = SRC_EVT;
            end
            default: begin
                w_src_val  = score;
                w_src_next = SRC_SCORE;
            end
        endcase
    end

    always_comb begin
        w_blink_cnt_next = r_blink_cnt;
        w_phase_next     = r_phase;
        if (!blink_en) begin
            w_blink_cnt_next = '0;
            w_phase_next     = 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == c_blink_last) begin
                w_blink_cnt_next = '0;
                w_phase_next     = ~r_phase;
            end else begin
                w_blink_cnt_next = r_blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_SCORE;
            r_dwell     <= '0;
            r_evt       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_num       <= '0;
            r_enable    <= 1'b0;
            r_src       <= SRC_SCORE;
            r_evt_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dwell     <= w_dwell_next;
            r_evt       <= w_evt_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_phase     <= w_phase_next;
            r_num       <= disp_sat(w_src_val);
            r_enable    <= w_phase_next;
            r_src       <= w_src_next;
            r_evt_ready <= (w_state_next != S_EVENT);
        end
    end

    assign num_out    = r_num;
    assign enable_out = r_enable;
    assign src        = r_src;
    assign evt_ready  = r_evt_ready;

endmodule
`default_nettype wire

// File: tb/tb_segdisplay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_segdisplay_scheduler
// Description : Self-checking bench for segdisplay_scheduler against a
//               tick-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segdisplay_scheduler;

    localparam int TD = 4;
    localparam int RT = 3;
    localparam int ET = 2;
    localparam int BT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] score = '0;
    logic [15:0] hiscore = '0;
    logic        show_hi = 1'b0;
    logic        evt_valid = 1'b0;
    logic [15:0] evt_num = '0;
    logic        evt_ready;
    logic        blink_en = 1'b0;
    logic [15:0] num_out;
    logic        enable_out;
    logic [1:0]  src;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: ticks since reset / in state / while blinking
    int          m_cyc = 0;
    int          m_state = 0;
    int          m_tis = 0;
    int          m_bt = 0;
    logic [15:0] m_evt = '0;
    logic [15:0] e_num = '0;
    logic [1:0]  e_src = '0;
    logic        e_en = 1'b0;
    logic        e_rdy = 1'b0;

    logic [19:0] got;
    logic [19:0] exp_v;

    segdisplay_scheduler #(
        .TICK_DIV     (TD),
        .ROTATE_TICKS (RT),
        .EVENT_TICKS  (ET),
        .BLINK_TICKS  (BT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .score      (score),
        .hiscore    (hiscore),
        .show_hi    (show_hi),
        .evt_valid  (evt_valid),
        .evt_num    (evt_num),
        .evt_ready  (evt_ready),
        .blink_en   (blink_en),
        .num_out    (num_out),
        .enable_out (enable_out),
        .src        (src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] clamp(input logic [15:0] v);
        return (v > 16'd9999) ? 16'd9999 : v;
    endfunction

    task automatic model_edge();
        bit tick;
        bit accept;
        int nxt;
        if (!rst_n) begin
            m_cyc = 0; m_state = 0; m_tis = 0; m_bt = 0; m_evt = '0;
            e_num = '0; e_src = '0; e_en = 1'b0; e_rdy = 1'b0;
        end else begin
            tick   = ((m_cyc % TD) == TD - 1);
            m_cyc  = m_cyc + 1;
            accept = evt_valid && e_rdy;
            nxt    = m_state;
            if (m_state == 0) begin
                if (accept) nxt = 2;
                else if (show_hi && tick && m_tis >= RT - 1) nxt = 1;
            end else if (m_state == 1) begin
                if (accept) nxt = 2;
                else if (!show_hi) nxt = 0;
                else if (tick && m_tis >= RT - 1) nxt = 0;
            end else begin
                if (tick && m_tis >= ET - 1) nxt = 0;
            end
            if (accept) m_evt = evt_num;
            if (nxt != m_state) m_tis = 0;
            else if (tick) m_tis = m_tis + 1;
            m_state = nxt;
            if (!blink_en) m_bt = 0;
            else if (tick) m_bt = m_bt + 1;
            e_en  = (((m_bt / BT) % 2) == 0);
            e_src = 2'(m_state);
            e_rdy = (m_state != 2);
            e_num = clamp((m_state == 0) ? score : (m_state == 1) ? hiscore : m_evt);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        got   = {num_out, src, enable_out, evt_ready};
        exp_v = {e_num, e_src, e_en, e_rdy};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        score = 16'd1234;
        repeat (3) cycle();
        n_cmp++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, 20'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        score   = 16'd1234;
        show_hi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL idle cyc%0d: got %h want %h", i, got, exp_v);
            end
        end
        n_cmp++;
        if (got !== {16'd1234, 2'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL idle_final: got %h want %h", got, {16'd1234, 2'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_rotate();
        bit found;
        score   = 16'd42;
        hiscore = 16'd9000;
        show_hi = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL rotate cyc%0d: got %h want %h", i, got, exp_v);
            end
        end
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (src == 2'd1) found = 1;
        end
        n_cmp++;
        if (!found || num_out !== 16'd9000) begin
            n_err++;
            $display("FAIL rotate_reach_hi: got src %0d num %0d want src 1 num 9000", src, num_out);
        end
        show_hi = 1'b0;
        cycle();
        n_cmp++;
        if (src !== 2'd0 || num_out !== 16'd42 || got !== exp_v) begin
            n_err++;
            $display("FAIL rotate_drop_hi: got %h want %h", got, exp_v);
        end
    endtask

    task automatic test_event();
        bit found;
        int hold_dut;
        int hold_ref;
        score   = 16'($urandom_range(0, 9999));
        show_hi = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (src == 2'd1) found = 1;
        end
        evt_valid = 1'b1;
        evt_num   = 16'd7777;
        cycle();
        evt_valid = 1'b0;
        n_cmp++;
        if (!found || got !== {16'd7777, 2'd2, e_en, 1'b0}) begin
            n_err++;
            $display("FAIL event_accept: got %h want %h", got, {16'd7777, 2'd2, e_en, 1'b0});
        end
        hold_dut = 1;
        hold_ref = 1;
        for (int i = 0; i < 20; i++) begin
            evt_valid = (i == 1);
            evt_num   = 16'd1111;
            cycle();
            if (src == 2'd2) hold_dut++;
            if (e_src == 2'd2) hold_ref++;
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL event_hold cyc%0d: got %h want %h", i, got, exp_v);
            end
        end
        evt_valid = 1'b0;
        n_cmp++;
        if (hold_dut !== hold_ref) begin
            n_err++;
            $display("FAIL event_hold_len: got %0d want %0d", hold_dut, hold_ref);
        end
        show_hi = 1'b0;
    endtask

    task automatic test_saturation();
        logic [15:0] vals [5];
        logic [15:0] want [5];
        vals = '{16'd12345, 16'd9999, 16'd0, 16'd10000, 16'hFFFF};
        want = '{16'd9999, 16'd9999, 16'd0, 16'd9999, 16'd9999};
        show_hi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            score = vals[i];
            cycle();
            n_cmp++;
            if (num_out !== want[i] || got !== exp_v) begin
                n_err++;
                $display("FAIL saturate score=%0d: got num %0d want %0d", vals[i], num_out, want[i]);
            end
        end
    endtask

    task automatic test_blink();
        bit found;
        score    = 16'd555;
        blink_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL blink cyc%0d: got %h want %h", i, got, exp_v);
            end
        end
        found = (enable_out == 1'b0);
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (enable_out == 1'b0) found = 1;
        end
        blink_en = 1'b0;
        cycle();
        n_cmp++;
        if (!found || enable_out !== 1'b1) begin
            n_err++;
            $display("FAIL blink_release: got en %0b found_off %0b want en 1", enable_out, found);
        end
    endtask

    task automatic test_reset_mid_event();
        score     = 16'd321;
        evt_valid = 1'b1;
        evt_num   = 16'd4242;
        cycle();
        evt_valid = 1'b0;
        cycle();
        n_cmp++;
        if (src !== 2'd2 || got !== exp_v) begin
            n_err++;
            $display("FAIL mid_event_setup: got %h want %h", got, exp_v);
        end
        rst_n = 1'b0;
        cycle();
        n_cmp++;
        if (got !== 20'h0) begin
            n_err++;
            $display("FAIL mid_event_reset: got %h want %h", got, 20'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_cmp++;
            if (got !== exp_v || src !== 2'd0 || num_out !== 16'd321) begin
                n_err++;
                $display("FAIL after_reset cyc%0d: got %h want %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) score = 16'($urandom_range(0, 12000));
            if ($urandom_range(0, 7) == 0) hiscore = 16'($urandom);
            if ($urandom_range(0, 19) == 0) show_hi = ~show_hi;
            if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
            evt_valid = ($urandom_range(0, 9) == 0);
            evt_num   = 16'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
            cycle();
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", i, got, exp_v);
            end
        end
        rst_n     = 1'b1;
        evt_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_rotate();
        test_event();
        test_saturation();
        test_blink();
        test_reset_mid_event();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
